csa_1bit: RTL and testbench
===========================

// Module: csa_1bit
// PURPOSE
//   Carry-save (3:2) compressor for the ALU multiplier/adder trees of the 5-stage MIPS pipeline.
//   Reduces three equally weighted operands x, y, z to a sum vector and a carry vector,
//   with no carry propagation between bit positions.
//   Default configuration is a single-bit combinational full adder.
//   An optional output register stage with valid tracking supports pipelined trees.
// PARAMETERS
//   WIDTH    1  operand/result width in bits (>=1)
//   OUT_REG  0  0: outputs combinational; 1: outputs registered (1-cycle latency)
// PORTS
//   clk        in   1      clock, rising edge; used only when OUT_REG=1
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      operands on x/y/z are valid this cycle
//   x          in   WIDTH  operand A
//   y          in   WIDTH  operand B
//   z          in   WIDTH  operand C
//   out_valid  out  1      cout/sum are valid
//   cout       out  WIDTH  carry vector; bit i has weight 2^(i+1), not pre-shifted
//   sum        out  WIDTH  sum vector; bit i has weight 2^i
// BEHAVIOUR
//   Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//   Per bit i, identical and independent:
//     sum[i]  = x[i] ^ y[i] ^ z[i]
//     cout[i] = (x[i]&y[i]) | (x[i]&z[i]) | (y[i]&z[i])
//   Invariant, all operands unsigned, evaluated at WIDTH+2 bits:
//     x + y + z == sum + (cout << 1).
//   WIDTH=1 truth: {cout,sum} = 2-bit count of ones in {x,y,z}.
//   No carry ripples between bits; the consumer shifts cout left by one.
//   Overflow or sign handling belongs to the consumer.
//   OUT_REG=0:
//     - cout/sum are purely combinational; out_valid = in_valid combinationally.
//     - clk and rst_n are ignored and have no effect on outputs.
//     - Outputs settle within the same delta as input changes; no state.
//   OUT_REG=1:
//     - On each rising clk edge, cout/sum/out_valid capture the combinational results
//       and in_valid. Latency is 1 cycle.
//     - cout/sum update every edge regardless of in_valid; out_valid qualifies them.
//     - rst_n low asynchronously forces cout=0, sum=0, out_valid=0 and holds them
//       while low.
//     - On the first edge after rst_n deasserts, the current inputs are captured.
//     - Reset asserted mid-stream discards the in-flight result; no recovery of lost data.
//   X/Z on an input bit propagates only to that bit position's outputs.
// STRUCTURE
//   Sub-module csa_cell: 1-bit full-adder cell (x,y,z -> cout,sum).
//   csa_1bit instantiates WIDTH csa_cell instances via a generate loop.
//   An optional generate-if output register block follows, controlled by OUT_REG.
//   Shared package alu_pkg:
//     - csa_ref(x,y,z) function returning {cout,sum}, for use by benches and assertions.
//     - Default WIDTH constant for the multiplier tree.
//   No FSM.
// TESTING
//   1. WIDTH=1, OUT_REG=0, all 8 combos of {x,y,z}:
//      000->c0 s0; 001,010,100->c0 s1; 011,101,110->c1 s0; 111->c1 s1.
//   2. WIDTH=1, 150 random vectors, checked 1 time-unit after each apply:
//      {cout,sum} == x+y+z; BOTH bits must match (fail if either differs).
//   3. WIDTH=8, OUT_REG=0, x=8'hFF y=8'h01 z=8'h80:
//      sum=8'h7E, cout=8'h81; sum+(cout<<1)=10'h180.
//   4. WIDTH=8, OUT_REG=1, in_valid=1, x=y=z=8'hAA:
//      one edge later cout=8'hAA, sum=8'hAA, out_valid=1.
//   5. OUT_REG=1, assert rst_n=0 between clock edges:
//      outputs go 0 immediately, not waiting for clk.
//      Release rst_n -> next edge captures the current inputs.
//   6. OUT_REG=1, in_valid toggling 1,0,1:
//      out_valid follows 1,0,1 delayed one cycle; data matches csa_ref.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the multiplier/adder trees.
// Carry-save reference function and tree width constants.
package alu_pkg;

  localparam int CSA_MAX_W  = 64;
  localparam int MUL_TREE_W = 32;

  // Returns {cout, sum}; callers truncate to their own width.
  function automatic logic [2*CSA_MAX_W-1:0] csa_ref(
    input logic [CSA_MAX_W-1:0] x,
    input logic [CSA_MAX_W-1:0] y,
    input logic [CSA_MAX_W-1:0] z
  );
    logic [CSA_MAX_W-1:0] c;
    logic [CSA_MAX_W-1:0] s;
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
    return {c, s};
  endfunction

endpackage

// File: rtl/csa_cell.sv
// One-bit full-adder cell: three equal-weight inputs
// reduced to a sum bit and a carry bit.
module csa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic cout,
  output logic sum
);

  assign sum  = x ^ y ^ z;
  assign cout = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_1bit.sv
// Carry-save 3:2 compressor, WIDTH independent cells,
// with an optional output register stage carrying valid.
module csa_1bit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] w_cout;
  logic [WIDTH-1:0] w_sum;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    csa_cell u_cell (
      .x    (x[i]),
      .y    (y[i]),
      .z    (z[i]),
      .cout (w_cout[i]),
      .sum  (w_sum[i])
    );
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] r_cout;
    logic [WIDTH-1:0] r_sum;
    logic             r_valid;

    // Data updates every edge; r_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cout  <= '0;
        r_sum   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_cout  <= w_cout;
        r_sum   <= w_sum;
        r_valid <= in_valid;
      end
    end

    assign cout      = r_cout;
    assign sum       = r_sum;
    assign out_valid = r_valid;
  end else begin : g_comb
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign cout      = w_cout;
    assign sum       = w_sum;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_csa_1bit.sv
// Bench for csa_1bit: combinational 1- and 8-bit instances
// plus a registered 8-bit instance, against an arithmetic model.
module tb_csa_1bit;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic       a_v, a_x, a_y, a_z, a_ov, a_c, a_s;
  logic       b_v, b_ov;
  logic [7:0] b_x, b_y, b_z, b_c, b_s;
  logic       c_v, c_ov;
  logic [7:0] c_x, c_y, c_z, c_c, c_s;

  csa_1bit #(.WIDTH(1), .OUT_REG(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_v),
    .x(a_x), .y(a_y), .z(a_z),
    .out_valid(a_ov), .cout(a_c), .sum(a_s)
  );

  csa_1bit #(.WIDTH(8), .OUT_REG(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_v),
    .x(b_x), .y(b_y), .z(b_z),
    .out_valid(b_ov), .cout(b_c), .sum(b_s)
  );

  csa_1bit #(.WIDTH(8), .OUT_REG(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_v),
    .x(c_x), .y(c_y), .z(c_z),
    .out_valid(c_ov), .cout(c_c), .sum(c_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-position population count of the three operand bits.
  function automatic logic [15:0] model8(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic [7:0] z);
    logic [7:0] c;
    logic [7:0] s;
    int n;
    for (int i = 0; i < 8; i++) begin
      n = int'(x[i]) + int'(y[i]) + int'(z[i]);
      s[i] = (n % 2) == 1;
      c[i] = n >= 2;
    end
    return {c, s};
  endfunction

  task automatic check_b(input string tag);
    logic [15:0] e;
    logic [9:0]  tot;
    logic [9:0]  rec;
    e   = model8(b_x, b_y, b_z);
    tot = 10'(b_x) + 10'(b_y) + 10'(b_z);
    rec = 10'(b_s) + (10'(b_c) << 1);
    chk({tag, "_data"}, {16'h0, b_c, b_s}, {16'h0, e});
    chk({tag, "_sumeq"}, {22'h0, rec}, {22'h0, tot});
  endtask

  task automatic reg_cycle(input string tag);
    logic [15:0] e;
    logic        ev;
    e  = model8(c_x, c_y, c_z);
    ev = c_v;
    @(posedge clk);
    #1;
    chk({tag, "_v"}, {31'h0, c_ov}, {31'h0, ev});
    chk({tag, "_d"}, {16'h0, c_c, c_s}, {16'h0, e});
  endtask

  initial begin
    logic [2:0]   cnt;
    logic [127:0] r;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    {a_v, a_x, a_y, a_z} = '0;
    {b_v, b_x, b_y, b_z} = '0;
    {c_v, c_x, c_y, c_z} = '0;
    #2;
    chk("reset_v", {31'h0, c_ov}, 32'h0);
    chk("reset_d", {16'h0, c_c, c_s}, 32'h0);
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table
    for (int k = 0; k < 8; k++) begin
      {a_x, a_y, a_z} = 3'(k);
      a_v = k[0];
      #1;
      cnt = 3'(int'(a_x) + int'(a_y) + int'(a_z));
      chk("tt_cs", {30'h0, a_c, a_s}, {30'h0, cnt[1:0]});
      chk("tt_v", {31'h0, a_ov}, {31'h0, a_v});
    end

    for (int k = 0; k < 150; k++) begin
      {a_v, a_x, a_y, a_z} = 4'($urandom);
      #1;
      cnt = 3'(int'(a_x) + int'(a_y) + int'(a_z));
      chk("rnd1", {30'h0, a_c, a_s}, {30'h0, cnt[1:0]});
    end

    b_v = 1'b1;
    b_x = 8'hFF; b_y = 8'h01; b_z = 8'h80;
    #1;
    chk("w8_sum", {24'h0, b_s}, 32'h7E);
    chk("w8_cout", {24'h0, b_c}, 32'h81);
    check_b("w8_fixed");

    for (int k = 0; k < 40; k++) begin
      b_x = 8'($urandom); b_y = 8'($urandom); b_z = 8'($urandom);
      b_v = 1'($urandom);
      #1;
      check_b("w8_rnd");
      chk("w8_v", {31'h0, b_ov}, {31'h0, b_v});
    end

    // Registered instance: align to just after an edge
    @(posedge clk);
    #1;
    c_v = 1'b1; c_x = 8'hAA; c_y = 8'hAA; c_z = 8'hAA;
    reg_cycle("aa");
    chk("aa_c", {24'h0, c_c}, 32'hAA);
    chk("aa_s", {24'h0, c_s}, 32'hAA);

    // Async reset between edges; comb instance must not react
    c_x = 8'h0F; c_y = 8'hF0; c_z = 8'h3C; c_v = 1'b1;
    b_x = 8'h12; b_y = 8'h34; b_z = 8'h56;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_v", {31'h0, c_ov}, 32'h0);
    chk("arst_d", {16'h0, c_c, c_s}, 32'h0);
    check_b("comb_in_rst");
    #1;
    rst_n = 1'b1;
    c_x = 8'h5A; c_y = 8'hC3; c_z = 8'h99;
    reg_cycle("post_rst");

    for (int k = 0; k < 3; k++) begin
      c_v = (k != 1);
      r = csa_ref(64'($urandom), 64'($urandom), 64'($urandom));
      c_x = 8'($urandom); c_y = 8'($urandom); c_z = 8'($urandom);
      r = csa_ref(64'(c_x), 64'(c_y), 64'(c_z));
      @(posedge clk);
      #1;
      chk("tog_v", {31'h0, c_ov}, {31'h0, (k != 1)});
      chk("tog_d", {16'h0, c_c, c_s}, {16'h0, r[71:64], r[7:0]});
    end

    for (int k = 0; k < 40; k++) begin
      c_v = 1'($urandom);
      c_x = 8'($urandom); c_y = 8'($urandom); c_z = 8'($urandom);
      reg_cycle("reg_rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
